// File: rtl/adc_fifo_rd_pkt_if.sv
// AXI4-Stream link from the ADC FIFO packetiser to the DMA/stream sink.
// The packetiser drives data/valid/last; the sink drives ready.
interface adc_fifo_rd_pkt_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_fifo_rd_pkt.sv
// adc_fifo_rd_pkt: read side of the ADC sample FIFO.
// Pops 32-bit words {pad, adc_1, pad, adc_2} from a standard (non-FWFT) FIFO
// and emits one AXI4-Stream packet of pkt_len words per start pulse, tlast on
// the final word. A 2-entry skid buffer absorbs downstream backpressure and
// the FIFO's one-cycle read latency while sustaining one word per clock.
//
// Optional feature: define ADC_FIFO_RD_SIGNEXT_EN to rewrite each 16-bit half
// as the sign extension of its SAMPLE_W-bit sample. Undefined, words pass
// through unmodified. Either way the path adds no latency.
module adc_fifo_rd_pkt #(
    parameter int LEN_W    = 16,
    parameter int SAMPLE_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [31:0]       fifo_rdata,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    adc_fifo_rd_pkt_if.master m_axis,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_sent
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;

    logic [LEN_W-1:0] len_q;       // packet length latched at start
    logic [LEN_W-1:0] issued_q;    // FIFO pops issued this packet
    logic [LEN_W-1:0] wr_cnt_q;    // words written into the skid buffer this packet
    logic [LEN_W-1:0] sent_q;      // beats accepted downstream this packet
    logic             inflight_q;  // a pop was issued last cycle; data arrives now

    logic [31:0]      buf_data_q [2];
    logic             buf_last_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;

    logic             beat;
    logic             last_beat;
    logic             take_start;
    logic [2:0]       committed;
    logic [31:0]      word_in;

    // Rewrites the pad bits of one 16-bit half (identity when the feature is off).
    function automatic logic [15:0] fix_half(input logic [15:0] half);
        logic [15:0] res;
        res = half;
`ifdef ADC_FIFO_RD_SIGNEXT_EN
        for (int b = SAMPLE_W; b < 16; b++) begin
            res[b] = half[SAMPLE_W-1];
        end
`endif
        return res;
    endfunction

    assign word_in = {fix_half(fifo_rdata[31:16]), fix_half(fifo_rdata[15:0])};

    assign m_axis.tvalid = (occ_q != 2'd0);
    assign m_axis.tdata  = buf_data_q[rd_ptr_q];
    assign m_axis.tlast  = m_axis.tvalid && buf_last_q[rd_ptr_q];

    assign beat       = m_axis.tvalid && m_axis.tready;
    assign last_beat  = beat && m_axis.tlast;
    assign take_start = start && !abort && (pkt_len != '0);

    // Slots the buffer will still hold after this cycle's beat, counting the
    // word already in flight. A new pop is safe only while this is below 2;
    // crediting the current beat is what allows one word per clock.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, beat};

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign words_sent = sent_q;

    // Next-state and FIFO pop decision; abort overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                fifo_rd_en = !fifo_empty && (issued_q < len_q) && (committed < 3'd2);
                if (last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            fifo_rd_en = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of block evaluation order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Packet counters: latched/cleared on a taken start, stepped by pops, writes and beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            issued_q <= '0;
            wr_cnt_q <= '0;
            sent_q   <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
            len_q    <= pkt_len;
            issued_q <= '0;
            wr_cnt_q <= '0;
            sent_q   <= '0;
        end else begin
            if (fifo_rd_en) issued_q <= issued_q + LEN_W'(1);
            if (inflight_q) wr_cnt_q <= wr_cnt_q + LEN_W'(1);
            // A beat handshaken in the abort cycle was still taken by the sink.
            if (beat)       sent_q   <= sent_q + LEN_W'(1);
        end
    end

    // Skid buffer: returning FIFO data goes to the tail, accepted beats retire the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two storage entries are reset on purpose so tdata reads
            // zero out of reset; a deep RAM-based buffer would not be reset.
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
        end else if (abort) begin
            // Flush: the pending beat and any word returning this cycle are dropped.
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (inflight_q) begin
                buf_data_q[wr_ptr_q] <= word_in;
                buf_last_q[wr_ptr_q] <= (wr_cnt_q == len_q - LEN_W'(1));
                wr_ptr_q             <= !wr_ptr_q;
            end
            if (beat) rd_ptr_q <= !rd_ptr_q;
            occ_q <= committed[1:0];
        end
    end

endmodule

// File: tb/tb_adc_fifo_rd_pkt.sv
// Self-checking bench for adc_fifo_rd_pkt: a behavioural FIFO feeds the DUT,
// expected beats are queued from the FIFO contents at each start and popped
// as the DUT hands beats to the sink.
module tb_adc_fifo_rd_pkt;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] pkt_len;
    logic [31:0]      fifo_rdata = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_sent;

    adc_fifo_rd_pkt_if axis ();

    adc_fifo_rd_pkt dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pkt_len    (pkt_len),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_axis     (axis),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected output word for a FIFO word (14-bit samples).
    function automatic logic [31:0] expect_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ADC_FIFO_RD_SIGNEXT_EN
        r[31:30] = {2{w[29]}};
        r[15:14] = {2{w[13]}};
`endif
        return r;
    endfunction

    // ---------------- FIFO model (standard read latency of one clock) ----------
    logic [31:0] fifo_q[$];
    int pop_total = 0;
    int gap_at    = 0;   // start an empty gap once this many pops past gap_base
    int gap_base  = 0;
    int gap_left  = 0;

    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            check("pop_while_empty", {31'b0, fifo_empty}, 32'd0);
            if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
            pop_total++;
            if (gap_at != 0 && (pop_total - gap_base) == gap_at) gap_left = 10;
        end else if (gap_left > 0) begin
            gap_left--;
        end
        fifo_empty <= (gap_left > 0) || (fifo_q.size() == 0);
    end

    // ---------------- Scoreboard and stream monitor ----------------------------
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          beat_cyc_q[$];
    int          cyc        = 0;
    logic        last_acc   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    logic [31:0] last_data  = '0;

    always @(posedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            last_acc   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done || last_acc) check("done_after_tlast", {31'b0, done}, {31'b0, last_acc});
            if (prev_stall) begin
                check("hold_tvalid", {31'b0, axis.tvalid}, 32'd1);
                check("hold_tdata", axis.tdata, prev_data);
                check("hold_tlast", {31'b0, axis.tlast}, {31'b0, prev_last});
            end
            if (axis.tvalid && axis.tready) begin
                check("sb_has_entry", {31'b0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_tdata", axis.tdata, e.data);
                    check("beat_tlast", {31'b0, axis.tlast}, {31'b0, e.last});
                end
                beat_cyc_q.push_back(cyc);
                last_data = axis.tdata;
            end
            last_acc   = axis.tvalid && axis.tready && axis.tlast && !abort;
            prev_stall = axis.tvalid && !axis.tready && !abort;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
        end
    end

    // ---------------- Stimulus helpers ----------------------------------------
    int pop_snap  = 0;
    int beat_snap = 0;

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back($urandom());
    endtask

    task automatic pulse_start(input int len);
        pkt_len = LEN_W'(len);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Queues the expected packet from the FIFO's current front, then starts it.
    task automatic start_pkt(input int len);
        pop_snap  = pop_total;
        beat_snap = beat_cyc_q.size();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{data: expect_word(fifo_q[i]), last: (i == len - 1)});
        end
        pulse_start(len);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        @(negedge clk);
    endtask

    // ---------------- Main sequence -------------------------------------------
    logic [3:0] rdy_pat;

    initial begin
        int n;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        pkt_len     = '0;
        axis.tready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tvalid", {31'b0, axis.tvalid}, 32'd0);
        check("rst_tlast", {31'b0, axis.tlast}, 32'd0);
        check("rst_tdata", axis.tdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("rst_words_sent", {16'b0, words_sent}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic packet: 8 words queued, 4 sent back to back.
        preload(8);
        @(negedge clk);
        axis.tready = 1'b1;
        start_pkt(4);
        check("t1_tvalid_c0", {31'b0, axis.tvalid}, 32'd0);
        @(negedge clk);
        check("t1_tvalid_c1", {31'b0, axis.tvalid}, 32'd0);
        @(negedge clk);
        check("t1_tvalid_c2", {31'b0, axis.tvalid}, 32'd1);
        wait_done(50);
        check("t1_words_sent", {16'b0, words_sent}, 32'd4);
        check("t1_pops", pop_total - pop_snap, 32'd4);
        check("t1_fifo_left", fifo_q.size(), 32'd4);
        check("t1_beats", beat_cyc_q.size() - beat_snap, 32'd4);
        check("t1_back_to_back", beat_cyc_q[beat_snap + 3] - beat_cyc_q[beat_snap], 32'd3);
        check("t1_busy_after", {31'b0, busy}, 32'd0);

        // Backpressure: tready pattern 1,0,0,1.
        preload(4);
        @(negedge clk);
        rdy_pat = 4'b1001;
        start_pkt(6);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            axis.tready = rdy_pat[n % 4];
            @(negedge clk);
            n++;
        end
        axis.tready = 1'b1;
        wait_done(50);
        check("t2_words_sent", {16'b0, words_sent}, 32'd6);
        check("t2_pops", pop_total - pop_snap, 32'd6);

        // FIFO empty for 10 clocks after the second pop.
        preload(6);
        @(negedge clk);
        gap_base = pop_total;
        gap_at   = 2;
        start_pkt(5);
        n = 0;
        while (gap_left == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("t3_tvalid_gap", {31'b0, axis.tvalid}, 32'd0);
        check("t3_busy_gap", {31'b0, busy}, 32'd1);
        check("t3_pops_gap", pop_total - pop_snap, 32'd2);
        wait_done(100);
        gap_at = 0;
        check("t3_words_sent", {16'b0, words_sent}, 32'd5);
        check("t3_pops", pop_total - pop_snap, 32'd5);

        // Abort with a beat pending under backpressure and a word in flight.
        preload(4);
        @(negedge clk);
        axis.tready = 1'b0;
        start_pkt(4);
        n = 0;
        while (axis.tvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_tvalid_before", {31'b0, axis.tvalid}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_tvalid_abort", {31'b0, axis.tvalid}, 32'd0);
        check("t4_busy_abort", {31'b0, busy}, 32'd0);
        check("t4_pops_abort", pop_total - pop_snap, 32'd2);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("t4_tvalid_idle", {31'b0, axis.tvalid}, 32'd0);
        axis.tready = 1'b1;
        start_pkt(2);
        wait_done(50);
        check("t4_words_sent", {16'b0, words_sent}, 32'd2);

        // Sample-field handling of a known word, sent as the packet's last beat.
        fifo_q.push_back(32'h3FFF_2000);
        @(negedge clk);
        start_pkt(fifo_q.size());
        wait_done(50);
`ifdef ADC_FIFO_RD_SIGNEXT_EN
        check("t5_signext_word", last_data, 32'hFFFF_E000);
`else
        check("t5_passthru_word", last_data, 32'h3FFF_2000);
`endif

        // Ignored starts: zero length in IDLE, any start while busy.
        preload(4);
        @(negedge clk);
        pop_snap = pop_total;
        pulse_start(0);
        repeat (5) @(negedge clk);
        check("t6_len0_busy", {31'b0, busy}, 32'd0);
        check("t6_len0_pops", pop_total - pop_snap, 32'd0);
        check("t6_len0_tvalid", {31'b0, axis.tvalid}, 32'd0);
        axis.tready = 1'b0;
        start_pkt(3);
        repeat (3) @(negedge clk);
        check("t6_busy_run", {31'b0, busy}, 32'd1);
        pulse_start(7);
        repeat (3) @(negedge clk);
        axis.tready = 1'b1;
        wait_done(50);
        check("t6_words_sent", {16'b0, words_sent}, 32'd3);
        check("t6_pops", pop_total - pop_snap, 32'd3);
        check("t6_fifo_left", fifo_q.size(), 32'd1);
        repeat (5) @(negedge clk);
        check("t6_no_restart", {31'b0, busy}, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
